trigger_phase_ctrl: RTL and testbench
=====================================

# trigger_phase_ctrl

Sequences the dynamic phase-shift port of the trigger-clock MMCM that feeds the trace capture logic. A USB-written signed target phase is reached by issuing single psen/psincdec steps and waiting for each psdone. The block tracks the current applied offset, handles MMCM lock loss and step timeouts, and runs in the USB clock domain, which also clocks the MMCM phase-shift port.

## Interface
Parameters:
- pPHASE_WIDTH, 16: width of the signed phase position, in MMCM fine-shift steps.
- pTIMEOUT, 255: usb_clk cycles to wait for psdone after psen before flagging an error.

Ports:
- usb_clk  in  1  single clock; the MMCM psclk is driven from the same net.
- resetn  in  1  reset, asynchronous, active-low.
- I_target_phase  in  pPHASE_WIDTH  signed target offset; sampled only on I_go.
- I_go  in  1  one-cycle request to move to I_target_phase.
- I_abort  in  1  one-cycle request to stop after any outstanding step.
- I_locked  in  1  MMCM locked; treated as already synchronous.
- I_psdone  in  1  MMCM phase-shift done, one cycle wide.
- O_psen  out  1  MMCM phase-shift enable, one-cycle pulse.
- O_psincdec  out  1  step direction: 1 = increment, 0 = decrement.
- O_current_phase  out  pPHASE_WIDTH  signed offset applied so far.
- O_busy  out  1  high while a move is in progress.
- O_done  out  1  one-cycle pulse when current equals target.
- O_error  out  1  sticky timeout flag; cleared by I_go.

## Operation
- Reset values: all outputs 0; target register 0; state IDLE.
- States:
  - IDLE: on I_go, load the target and clear O_error.
    - If I_locked=0, go to WAIT_LOCK.
    - Else if target = current, pulse O_done and stay in IDLE.
    - Else go to STEP.
  - WAIT_LOCK: hold until I_locked=1, then evaluate the target as IDLE does. O_busy=1.
  - STEP: assert O_psen for one cycle, with O_psincdec = (target > current), signed compare. Go to WAIT_DONE and start the timeout counter.
  - WAIT_DONE: on I_psdone, add or subtract 1 from current by the latched direction.
    - If the new current = target, or an abort is pending, go to IDLE and pulse O_done.
    - Else go to STEP.
    - If the counter reaches pTIMEOUT, set O_error, leave current unchanged, and go to ERR.
  - ERR: O_busy=0. Stay until I_go, which behaves as it does in IDLE.
- I_go while busy: reload the target and continue from the present state. The direction is re-evaluated at the next STEP. An in-flight step is never cancelled.
- I_abort:
  - In STEP or WAIT_DONE: latch a pending abort and finish the outstanding psdone. No O_done pulse is issued for an abort.
  - In WAIT_LOCK: go to IDLE immediately.
  - In IDLE or ERR: ignored.
- I_go and I_abort in the same cycle: I_go wins.
- Lock loss (I_locked=0) in any state: O_current_phase is forced to 0, because an MMCM reset clears its dynamic offset. Any outstanding psdone is discarded. From STEP or WAIT_DONE, go to WAIT_LOCK; the target is retained and the move resumes from 0 after relock.
- I_psdone outside WAIT_DONE: ignored, with no error.
- Arithmetic: current is signed pPHASE_WIDTH. Current only moves toward a target that fits in the same width, so there is no overflow and no wrap.

## Timing
- I_go at edge 0 (locked, target ≠ current): O_busy=1 and O_psen=1 in cycle 1.
- Step cadence: psdone seen in cycle k gives the current update in cycle k+1 and the next O_psen in cycle k+2, i.e. a minimum of 2 cycles between psen pulses.
- Final psdone in cycle k: O_done=1 and O_busy=0 in cycle k+1, together with the updated O_current_phase.
- I_go with target = current: O_done in cycle 1; no psen.
- Timeout: O_error rises exactly pTIMEOUT cycles after the O_psen cycle if no psdone arrives.
- resetn asserted mid-move: all outputs go to 0 immediately. The MMCM is reset alongside, so current = 0 stays consistent.

## Structure
- State encoding is a localparam set in the trace shared definitions header, so trace_top register readback can decode it.
- Single module; no sub-module. The timeout counter is inline, with width $clog2(pTIMEOUT+1).
- Instantiated by trace_top next to the USB register block, driving trigger_clk_psen, trigger_clk_psincdec and trigger_clk_psdone.

## Test plan
- Reset, then I_go with target +3 and psdone 4 cycles after each psen → 3 psen pulses with psincdec=1; O_current_phase goes 1, 2, 3; O_done once; O_busy low after.
- From current +3, I_go with target −2 → 5 pulses with psincdec=0; final O_current_phase = −2 (0xFFFE).
- psdone withheld, pTIMEOUT=255 → O_error=1 exactly 255 cycles after psen; current unchanged; next I_go clears O_error.
- I_locked dropped while waiting for the 2nd of 4 steps toward +4 → current=0 and state WAIT_LOCK; late psdone ignored; after relock, 4 new steps; ends at +4.
- I_abort in cycle 1 of a move toward +10 → the outstanding step completes, ending at current=1, IDLE, no O_done; I_go and I_abort in the same cycle → move proceeds.
- I_go with target = current (0) → O_done in cycle 1; no O_psen.

Source files
------------

// File: rtl/trigger_phase_ctrl_pkg.sv
// Shared definitions for the trigger-clock MMCM phase sequencer: state
// encoding (decoded by register readback) and default sizing.
package trigger_phase_ctrl_pkg;

    localparam int DEFAULT_PHASE_WIDTH = 16;
    localparam int DEFAULT_TIMEOUT     = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STEP      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ERR       = 3'd4
    } phase_state_t;

    function automatic logic is_busy_state(input phase_state_t s);
        return (s == ST_WAIT_LOCK) || (s == ST_STEP) || (s == ST_WAIT_DONE);
    endfunction

endpackage

// File: rtl/trigger_phase_ctrl_if.sv
// Request/status and MMCM phase-shift port bundle for trigger_phase_ctrl.
// master = register block + MMCM side, slave = the sequencer.
interface trigger_phase_ctrl_if #(
    parameter int pPHASE_WIDTH = trigger_phase_ctrl_pkg::DEFAULT_PHASE_WIDTH
);
    logic signed [pPHASE_WIDTH-1:0] I_target_phase;
    logic                           I_go;
    logic                           I_abort;
    logic                           I_locked;
    logic                           I_psdone;
    logic                           O_psen;
    logic                           O_psincdec;
    logic signed [pPHASE_WIDTH-1:0] O_current_phase;
    logic                           O_busy;
    logic                           O_done;
    logic                           O_error;

    modport master (
        output I_target_phase, I_go, I_abort, I_locked, I_psdone,
        input  O_psen, O_psincdec, O_current_phase, O_busy, O_done, O_error
    );

    modport slave (
        input  I_target_phase, I_go, I_abort, I_locked, I_psdone,
        output O_psen, O_psincdec, O_current_phase, O_busy, O_done, O_error
    );
endinterface

// File: rtl/trigger_phase_ctrl.sv
// Walks the trigger-clock MMCM fine phase to a signed target one psen/psdone
// step at a time, tracking the applied offset through lock loss and timeouts.
module trigger_phase_ctrl
    import trigger_phase_ctrl_pkg::*;
#(
    parameter int pPHASE_WIDTH = DEFAULT_PHASE_WIDTH,
    parameter int pTIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic                 usb_clk,
    input  logic                 resetn,
    trigger_phase_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(pTIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(pTIMEOUT - 1);
    localparam logic signed [pPHASE_WIDTH-1:0] PHASE_ONE = pPHASE_WIDTH'(1);

    phase_state_t state_reg, state_next;
    logic signed [pPHASE_WIDTH-1:0] target_reg, target_next;
    logic signed [pPHASE_WIDTH-1:0] current_reg, current_next;
    logic signed [pPHASE_WIDTH-1:0] stepped_phase;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic dir_reg, dir_next;
    logic abort_reg, abort_next;
    logic hold_reg, hold_next;
    logic error_reg, error_next;
    logic done_reg, done_next;
    logic evaluate;

    always_ff @(posedge usb_clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            target_reg  <= '0;
            current_reg <= '0;
            cnt_reg     <= '0;
            dir_reg     <= 1'b0;
            abort_reg   <= 1'b0;
            hold_reg    <= 1'b0;
            error_reg   <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            target_reg  <= target_next;
            current_reg <= current_next;
            cnt_reg     <= cnt_next;
            dir_reg     <= dir_next;
            abort_reg   <= abort_next;
            hold_reg    <= hold_next;
            error_reg   <= error_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        current_next  = current_reg;
        cnt_next      = cnt_reg;
        dir_next      = dir_reg;
        hold_next     = 1'b0;
        error_next    = error_reg;
        done_next     = 1'b0;
        evaluate      = 1'b0;
        stepped_phase = dir_reg ? (current_reg + PHASE_ONE) : (current_reg - PHASE_ONE);

        if (bus.I_go) begin
            target_next = bus.I_target_phase;
            error_next  = 1'b0;
        end
        // An MMCM that lost lock has been reset, so its dynamic offset is gone.
        if (!bus.I_locked) begin
            current_next = '0;
        end
        abort_next = !bus.I_go && (abort_reg || bus.I_abort);

        case (state_reg)
            ST_IDLE, ST_ERR: begin
                evaluate = bus.I_go;
            end
            ST_WAIT_LOCK: begin
                if (bus.I_abort && !bus.I_go) begin
                    state_next = ST_IDLE;
                end else begin
                    evaluate = bus.I_locked;
                end
            end
            ST_STEP: begin
                dir_next = (target_reg > current_reg);
                cnt_next = CNT_W'(1);
                if (bus.I_locked) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    state_next = abort_next ? ST_IDLE : ST_WAIT_LOCK;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.I_locked) begin
                    state_next = abort_next ? ST_IDLE : ST_WAIT_LOCK;
                end else if (hold_reg) begin
                    // One settle cycle after each psdone keeps psen pulses two cycles apart.
                    if (abort_next) begin
                        state_next = ST_IDLE;
                    end else begin
                        evaluate = 1'b1;
                    end
                end else if (bus.I_psdone) begin
                    current_next = stepped_phase;
                    if (stepped_phase == target_next) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else if (abort_next) begin
                        state_next = ST_IDLE;
                    end else begin
                        hold_next = 1'b1;
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    error_next = 1'b1;
                    state_next = ST_ERR;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (evaluate) begin
            if (!bus.I_locked) begin
                state_next = ST_WAIT_LOCK;
            end else if (target_next == current_reg) begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end else begin
                state_next = ST_STEP;
            end
        end

        if (!((state_next == ST_STEP) || (state_next == ST_WAIT_DONE))) begin
            abort_next = 1'b0;
        end
    end

    always_comb begin
        bus.O_psen          = (state_reg == ST_STEP);
        bus.O_psincdec      = (state_reg == ST_STEP) && (target_reg > current_reg);
        bus.O_busy          = is_busy_state(state_reg);
        bus.O_current_phase = current_reg;
        bus.O_done          = done_reg;
        bus.O_error         = error_reg;
    end

endmodule

// File: tb/tb_trigger_phase_ctrl.sv
// Bench for trigger_phase_ctrl: plays the MMCM (answers psen with psdone after a
// chosen delay) and compares the reported phase against the MMCM's own offset.
module tb_trigger_phase_ctrl;

    localparam int W  = 16;
    localparam int TO = 255;

    logic usb_clk = 1'b0;
    logic resetn;

    trigger_phase_ctrl_if #(.pPHASE_WIDTH(W)) bus ();

    trigger_phase_ctrl #(.pPHASE_WIDTH(W), .pTIMEOUT(TO)) dut (
        .usb_clk (usb_clk),
        .resetn  (resetn),
        .bus     (bus)
    );

    always #5 usb_clk = ~usb_clk;

    typedef struct {
        int target;
        int delay;
        int pulses;
        int ups;
        int downs;
    } vec_t;

    int total = 0;
    int bad   = 0;

    int mm_phase = 0;     // offset the MMCM has actually applied
    int tgt      = 0;     // most recent requested target
    int pend     = 0;     // cycles until the outstanding psdone
    bit pend_dir = 1'b0;
    int delay    = 4;
    bit withhold = 1'b0;
    bit ghost    = 1'b0;  // outstanding psdone belongs to an MMCM that was reset
    int cyc      = 0;
    int last_ps_cyc = 0;
    int since_psen  = 0;
    int n_psen, n_up, n_down, n_done;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic cycle();
        @(negedge usb_clk);
        cyc++;
        bus.I_psdone = 1'b0;
        check("current_tracks_mmcm", $signed(bus.O_current_phase), mm_phase);
        if (pend > 0) begin
            pend--;
            if (pend == 0 && !withhold) begin
                bus.I_psdone = 1'b1;
                last_ps_cyc  = cyc;
                if (!ghost) mm_phase += pend_dir ? 1 : -1;
                ghost = 1'b0;
            end
        end
        if (bus.O_psen === 1'b1) begin
            check("psen_with_step_in_flight", pend, 0);
            check("psincdec_direction", bus.O_psincdec, (tgt > mm_phase));
            n_psen++;
            if (bus.O_psincdec) n_up++; else n_down++;
            pend       = delay;
            pend_dir   = bus.O_psincdec;
            since_psen = 0;
        end else begin
            since_psen++;
        end
        if (bus.O_done === 1'b1) begin
            n_done++;
            check("done_busy_low", bus.O_busy, 0);
            check("done_at_target", $signed(bus.O_current_phase), tgt);
            if (n_psen > 0) check("done_latency", cyc - last_ps_cyc, 1);
        end
    endtask

    task automatic do_go(input int t);
        bus.I_target_phase = W'(t);
        tgt       = t;
        bus.I_go  = 1'b1;
        cycle();
        bus.I_go  = 1'b0;
    endtask

    task automatic clear_counts();
        n_psen = 0; n_up = 0; n_down = 0; n_done = 0;
    endtask

    task automatic run_move(input int t, input int d, input bit ab, input int exp_n,
                            input int exp_up, input int exp_dn, input string tag);
        int start;
        start = mm_phase;
        delay = d;
        clear_counts();
        bus.I_abort = ab;
        do_go(t);
        bus.I_abort = 1'b0;
        check({tag, "_error_cleared"}, bus.O_error, 0);
        if (t != start) begin
            check({tag, "_cycle1_psen"}, bus.O_psen, 1);
            check({tag, "_cycle1_busy"}, bus.O_busy, 1);
        end else begin
            check({tag, "_cycle1_done"}, bus.O_done, 1);
            check({tag, "_cycle1_no_psen"}, bus.O_psen, 0);
        end
        for (int i = 0; i < 1000 && n_done == 0; i++) cycle();
        cycle();
        cycle();
        check({tag, "_done_count"}, n_done, 1);
        check({tag, "_psen_count"}, n_psen, exp_n);
        check({tag, "_inc_count"}, n_up, exp_up);
        check({tag, "_dec_count"}, n_down, exp_dn);
        check({tag, "_final_phase"}, $signed(bus.O_current_phase), t);
        check({tag, "_busy_after"}, bus.O_busy, 0);
    endtask

    task automatic model_move(input int t, input int d, input bit ab, input string tag);
        int n;
        n = (t > mm_phase) ? t - mm_phase : mm_phase - t;
        run_move(t, d, ab, n, (t > mm_phase) ? n : 0, (t < mm_phase) ? n : 0, tag);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   cur;
        vecs[0] = '{ 3, 4, 3, 3, 0};
        vecs[1] = '{-2, 4, 5, 0, 5};
        vecs[2] = '{-2, 1, 0, 0, 0};
        vecs[3] = '{ 5, 2, 7, 7, 0};
        vecs[4] = '{ 0, 7, 5, 0, 5};
        vecs[5] = '{-1, 3, 1, 0, 1};

        resetn             = 1'b0;
        bus.I_target_phase = '0;
        bus.I_go           = 1'b0;
        bus.I_abort        = 1'b0;
        bus.I_locked       = 1'b1;
        bus.I_psdone       = 1'b0;
        clear_counts();
        repeat (3) @(negedge usb_clk);
        resetn = 1'b1;
        cycle();
        check("reset_psen", bus.O_psen, 0);
        check("reset_psincdec", bus.O_psincdec, 0);
        check("reset_current", $signed(bus.O_current_phase), 0);
        check("reset_busy", bus.O_busy, 0);
        check("reset_done", bus.O_done, 0);
        check("reset_error", bus.O_error, 0);

        for (int v = 0; v < 6; v++) begin
            run_move(vecs[v].target, vecs[v].delay, 1'b0, vecs[v].pulses,
                     vecs[v].ups, vecs[v].downs, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 12; r++) begin
            int t;
            int d;
            t = int'($urandom_range(40)) - 20;
            d = int'($urandom_range(8, 1));
            model_move(t, d, 1'b0, $sformatf("rand%0d", r));
        end

        // psdone never arrives: error exactly TO cycles after psen
        cur      = mm_phase;
        delay    = 4;
        withhold = 1'b1;
        clear_counts();
        do_go(cur + 2);
        check("timeout_psen", bus.O_psen, 1);
        for (int i = 0; i < TO - 1; i++) cycle();
        check("timeout_cycles_counted", since_psen, TO - 1);
        check("timeout_error_not_yet", bus.O_error, 0);
        cycle();
        check("timeout_error_set", bus.O_error, 1);
        check("timeout_busy_low", bus.O_busy, 0);
        check("timeout_current_kept", $signed(bus.O_current_phase), cur);
        withhold = 1'b0;
        model_move(cur, 3, 1'b0, "after_timeout");

        // lock lost while the second of four steps is outstanding
        model_move(0, 3, 1'b0, "lock_setup");
        delay = 4;
        clear_counts();
        do_go(4);
        for (int i = 0; i < 50 && n_psen < 2; i++) cycle();
        check("lock_second_psen_seen", n_psen, 2);
        cycle();
        bus.I_locked = 1'b0;
        mm_phase     = 0;
        ghost        = (pend > 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("lock_wait_busy", bus.O_busy, 1);
            check("lock_wait_no_psen", bus.O_psen, 0);
        end
        bus.I_locked = 1'b1;
        for (int i = 0; i < 200 && n_done == 0; i++) cycle();
        cycle();
        check("lock_done_count", n_done, 1);
        check("lock_total_psen", n_psen, 6);
        check("lock_total_inc", n_up, 6);
        check("lock_final_phase", $signed(bus.O_current_phase), 4);

        // lock loss while idle still clears the offset
        bus.I_locked = 1'b0;
        mm_phase     = 0;
        cycle();
        check("idle_lockloss_busy", bus.O_busy, 0);
        check("idle_lockloss_current", $signed(bus.O_current_phase), 0);

        // abort while waiting for lock returns to idle at once
        clear_counts();
        do_go(5);
        check("waitlock_busy", bus.O_busy, 1);
        bus.I_abort = 1'b1;
        cycle();
        bus.I_abort = 1'b0;
        check("waitlock_abort_idle", bus.O_busy, 0);
        bus.I_locked = 1'b1;
        cycle();
        cycle();
        check("waitlock_abort_no_psen", n_psen, 0);
        check("waitlock_abort_no_done", n_done, 0);

        // abort in cycle 1 of a move to +10: outstanding step completes, no done
        model_move(0, 2, 1'b0, "abort_setup");
        delay = 4;
        clear_counts();
        do_go(10);
        bus.I_abort = 1'b1;
        cycle();
        bus.I_abort = 1'b0;
        for (int i = 0; i < 15; i++) cycle();
        check("abort_psen_count", n_psen, 1);
        check("abort_current", $signed(bus.O_current_phase), 1);
        check("abort_busy", bus.O_busy, 0);
        check("abort_no_done", n_done, 0);
        run_move(3, 4, 1'b1, 2, 2, 0, "go_and_abort");

        // asynchronous reset in the middle of a move
        delay = 4;
        clear_counts();
        do_go(mm_phase + 5);
        cycle();
        cycle();
        resetn = 1'b0;
        #1;
        check("midreset_current", $signed(bus.O_current_phase), 0);
        check("midreset_busy", bus.O_busy, 0);
        check("midreset_psen", bus.O_psen, 0);
        check("midreset_done", bus.O_done, 0);
        mm_phase = 0;
        pend     = 0;
        ghost    = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
        cycle();
        model_move(2, 3, 1'b0, "after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
